// File: rtl/alu_pkg.sv
// Shared encodings for the ALU and multiply/divide unit: operation selects,
// sequencer state type and default widths/latencies.
package alu_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/alu_md_seq.sv
// Multi-cycle multiply/divide sequencer: latches operands on launch, counts
// down the configured latency, then commits the result into HI/LO.
module alu_md_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    // Products are formed from zero/sign-extended operands so a plain
    // 2*WIDTH unsigned multiply yields the correct signed or unsigned result.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    assign prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
    assign prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

    // Signed divide works on magnitudes; the most-negative dividend's
    // magnitude fits unsigned, so most-negative / -1 yields most-negative, rem 0.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, uq_mag, ur_mag;
    logic [WIDTH-1:0] quot_s, rem_s, quot_u, rem_u;
    assign a_neg  = a_reg[WIDTH-1];
    assign b_neg  = b_reg[WIDTH-1];
    assign a_mag  = a_neg ? (~a_reg + 1'b1) : a_reg;
    assign b_mag  = b_neg ? (~b_reg + 1'b1) : b_reg;
    assign uq_mag = a_mag / b_mag;
    assign ur_mag = a_mag % b_mag;
    assign quot_s = (a_neg ^ b_neg) ? (~uq_mag + 1'b1) : uq_mag;
    assign rem_s  = a_neg ? (~ur_mag + 1'b1) : ur_mag;
    assign quot_u = a_reg / b_reg;
    assign rem_u  = a_reg % b_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            op_next    = md_op;
                            a_next     = a;
                            b_next     = b;
                            cnt_next   = CNT_W'(MUL_LAT);
                            state_next = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            op_next    = md_op;
                            a_next     = a;
                            b_next     = b;
                            cnt_next   = CNT_W'(DIV_LAT);
                            state_next = ST_BUSY;
                        end
                        MD_MTHI: hi_next = a;
                        MD_MTLO: lo_next = a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg - CNT_W'(1);
                // Commit on the edge that takes the counter to zero.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    case (op_reg)
                        MD_MULT:  {hi_next, lo_next} = prod_s;
                        MD_MULTU: {hi_next, lo_next} = prod_u;
                        MD_DIV: begin
                            if (b_reg != '0) begin
                                lo_next = quot_s;
                                hi_next = rem_s;
                            end
                        end
                        MD_DIVU: begin
                            if (b_reg != '0) begin
                                lo_next = quot_u;
                                hi_next = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_BUSY);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: rtl/alu_md.sv
// Combinational ALU plus the multi-cycle multiply/divide unit with HI/LO.
// The ALU result is independent of multiply/divide activity.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    logic [SHW-1:0] shamt;
    assign shamt = A[SHW-1:0];

    always_comb begin
        C = '0;
        case (ALUOp)
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_OR:   C = A | B;
            ALU_AND:  C = A & B;
            ALU_XOR:  C = A ^ B;
            ALU_NOR:  C = ~(A | B);
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  C = B << shamt;
            ALU_SRL:  C = B >> shamt;
            ALU_SRA:  C = $signed(B) >>> shamt;
            ALU_LUI:  C = {B[HALF-1:0], {HALF{1'b0}}};
            default:  C = '0;
        endcase
    end

    alu_md_seq #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .a       (A),
        .b       (B),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

endmodule
